predecode_fetch_buffer: RTL and testbench
=========================================

Name: predecode_fetch_buffer

Overview:
- Fetch-side pre-decode queue between the instruction fetch port and the decode stage.
- Each accepted instruction is pre-decoded on entry: jal, jalr, B-type, mv, and sw are classified, and a next-PC prediction is formed.
- Predicted-taken entries raise a registered redirect to fetch.
- A DEPTH-entry FIFO decouples fetch from decode, and a RAS_DEPTH-entry return-address stack predicts function returns.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- RAS_DEPTH, 8, return-address-stack entries; power of 2, at least 2.
- XLEN, 32, PC and data width; instruction width is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict or exception).
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  buffer can accept; equals !full.
- in_pc  in  XLEN  PC of in_instr.
- in_instr  in  32  raw instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry.
- out_pc  out  XLEN  head PC.
- out_instr  out  32  head instruction.
- out_is_jal, out_is_jalr, out_is_branch, out_is_mv, out_is_sw  out  1 each  pre-decode flags.
- out_pred_taken  out  1  prediction stored for the head entry.
- out_pred_target  out  XLEN  predicted next PC; in_pc+4 when not taken.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  XLEN  predicted target.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO becomes empty; read/write pointers and count are 0.
  - RAS pointer and count are 0.
  - redirect_valid=0 and redirect_pc=0.
  - out_valid=0; out_* data fields read 0.
  - Reset overrides flush and every handshake in the same cycle.
- Pre-decode (combinational on in_instr, opcode = in_instr[6:0]):
  - jal: opcode 1101111; imm = {sext(i[31]), i[19:12], i[20], i[30:21], 0}.
  - jalr: opcode 1100111; imm = sext(i[31:20]).
  - branch: opcode 1100011 with func3 in {000, 001, 100, 101, 110, 111}; imm = {sext(i[31]), i[7], i[30:25], i[11:8], 0}.
  - mv: opcode 0010011, func3 000, i[31:20]==0.
  - sw: opcode 0100011, func3 010.
- Prediction (all adds are modulo 2^XLEN):
  - jal: taken; target = pc+imm.
  - branch: taken iff imm<0 (i[31]=1, backward-taken/forward-not-taken); target = pc+imm if taken, else pc+4.
  - jalr with rd==x0, rs1==x1, RAS non-empty: taken; target = RAS top, bit 0 cleared.
  - Any other jalr, or RAS empty: not taken; target = pc+4.
  - Everything else: not taken; target = pc+4.
- RAS (updated only on accept, i.e. in_valid & in_ready & !flush):
  - Push pc+4 when (jal or jalr) and rd==x1.
  - Pop when jalr with rd==x0 and rs1==x1.
  - Push and pop are mutually exclusive by construction.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no pointer change.
  - flush does not modify the RAS.
- FIFO:
  - Entry stores pc, instr, the five flags, pred_taken, and pred_target.
  - Latency: an instruction accepted at edge N is visible on out_* after edge N; no input-to-output bypass.
  - Dequeue happens when out_valid & out_ready.
  - Simultaneous enqueue and dequeue: count unchanged.
  - When full, in_ready=0 even if a dequeue occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - out_* data when empty is don't-care, except after reset.
- Redirect:
  - An accept with pred_taken=1 at edge N gives redirect_valid=1 and redirect_pc=target for exactly the following cycle.
  - Accepts with pred_taken=0 produce no redirect.
- Flush:
  - At the edge, FIFO becomes empty and redirect_valid is cleared.
  - A concurrent input is dropped: no enqueue, no RAS update, no redirect.
  - out_valid=0 in the next cycle.
  - in_ready stays !full; after a flush the FIFO is not full, so in_ready=1.

Test Plan:
- Reset, then stream 6 non-control instructions (addi x2,x2,1 = 0x00110113) with out_ready=0 -> exactly 4 accepted; in_ready=0 from cycle 4 on; out_valid one cycle after the first accept; drain yields the same PCs in order.
- pc=0x1000, jal x1,+0x100 (0x100000EF) -> out_is_jal=1, pred_target=0x1100; redirect pulse with pc 0x1100; RAS top=0x1004. Then ret (0x00008067) at 0x1100 -> target 0x1004, RAS empty.
- pc=0x2008, beq x0,x0,-8 (0xFE000CE3) -> pred_taken=1, target=0x2000. Forward beq +8 (0x00000463) -> pred_taken=0, target=pc+4, no redirect.
- ret with RAS empty -> pred_taken=0, target=pc+4. Then 9 calls with RAS_DEPTH=8 and 9 rets -> the first 8 rets return in LIFO order, the 9th is not taken.
- Full FIFO plus a taken jal with flush=1 in the same cycle -> next cycle out_valid=0, redirect_valid=0, RAS unchanged, in_ready=1.
- Simultaneous enqueue and dequeue at count 2 over 20 cycles -> count stays 2, no loss or duplication; pointer wrap is exercised.

Source files
------------

// File: rtl/predecode_fetch_buffer_if.sv
// Fetch/decode/redirect bundle for predecode_fetch_buffer.
//   slave  : the buffer (consumes in_*, produces out_* and redirect_*)
//   master : the surrounding fetch/decode logic (or a testbench)
// Signals:
//   in_valid/in_ready/in_pc/in_instr        fetch -> buffer handshake
//   out_valid/out_ready/out_*               buffer -> decode handshake and pre-decoded head
//   redirect_valid/redirect_pc              one-cycle predicted-taken redirect to fetch
interface predecode_fetch_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_is_jal;
  logic            out_is_jalr;
  logic            out_is_branch;
  logic            out_is_mv;
  logic            out_is_sw;
  logic            out_pred_taken;
  logic [XLEN-1:0] out_pred_target;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_is_jal, out_is_jalr, out_is_branch,
           out_is_mv, out_is_sw, out_pred_taken, out_pred_target, redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_is_jal, out_is_jalr, out_is_branch,
           out_is_mv, out_is_sw, out_pred_taken, out_pred_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/predecode_fetch_buffer.sv
// Pre-decoding fetch queue. Each accepted instruction is classified (jal, jalr, branch, mv, sw),
// given a next-PC prediction (static BTFN for branches, RAS for returns) and stored in a
// DEPTH-entry FIFO. Predicted-taken accepts pulse a registered redirect one cycle later.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset (overrides everything)
//   flush empties the FIFO, kills redirect, drops the concurrent input (RAS untouched)
//   bus   predecode_fetch_buffer_if.slave: fetch input, decode output, redirect
module predecode_fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned XLEN      = 32
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  predecode_fetch_buffer_if.slave bus
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RasCntW = RasPtrW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic            is_mv;
    logic            is_sw;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [XLEN-1:0]     ras_q [RAS_DEPTH];
  logic [RasPtrW-1:0]  ras_ptr_q, ras_ptr_d;  // next free slot; top is ras_ptr_q-1
  logic [RasCntW-1:0]  ras_cnt_q, ras_cnt_d;
  logic                redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]     redir_pc_q, redir_pc_d;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [4:0]      rd, rs1;
  logic            is_jal, is_jalr, is_branch, is_mv, is_sw, is_call, is_ret;
  logic [XLEN-1:0] imm_j, imm_b, pc_plus4, ras_top;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            full, accept, deq;
  entry_t          new_entry, head;

  // Pre-decode and prediction on the incoming instruction.
  always_comb begin
    instr     = bus.in_instr;
    opcode    = instr[6:0];
    func3     = instr[14:12];
    rd        = instr[11:7];
    rs1       = instr[19:15];
    is_jal    = (opcode == 7'b1101111);
    is_jalr   = (opcode == 7'b1100111);
    is_branch = (opcode == 7'b1100011) && (func3 != 3'b010) && (func3 != 3'b011);
    is_mv     = (opcode == 7'b0010011) && (func3 == 3'b000) && (instr[31:20] == 12'h000);
    is_sw     = (opcode == 7'b0100011) && (func3 == 3'b010);
    is_call   = (is_jal || is_jalr) && (rd == 5'd1);
    is_ret    = is_jalr && (rd == 5'd0) && (rs1 == 5'd1);
    imm_j     = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_b     = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    pc_plus4  = bus.in_pc + XLEN'(4);
    ras_top   = ras_q[ras_ptr_q - RasPtrW'(1)];

    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    if (is_jal) begin
      pred_taken  = 1'b1;
      pred_target = bus.in_pc + imm_j;
    end else if (is_branch && instr[31]) begin
      // Backward branches predicted taken, forward not taken.
      pred_taken  = 1'b1;
      pred_target = bus.in_pc + imm_b;
    end else if (is_ret && (ras_cnt_q != '0)) begin
      pred_taken  = 1'b1;
      pred_target = {ras_top[XLEN-1:1], 1'b0};
    end

    new_entry = '{pc: bus.in_pc, instr: instr, is_jal: is_jal, is_jalr: is_jalr,
                  is_branch: is_branch, is_mv: is_mv, is_sw: is_sw,
                  pred_taken: pred_taken, pred_target: pred_target};
  end

  // FIFO, RAS and redirect next-state.
  always_comb begin
    full   = (count_q == CntW'(DEPTH));
    accept = bus.in_valid && !full && !flush;
    deq    = (count_q != '0) && bus.out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq)    rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({accept, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (accept && is_call) begin
      // Pushing onto a full stack overwrites the oldest entry; count saturates.
      ras_ptr_d = ras_ptr_q + RasPtrW'(1);
      if (ras_cnt_q != RasCntW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RasCntW'(1);
    end else if (accept && is_ret && (ras_cnt_q != '0)) begin
      ras_ptr_d = ras_ptr_q - RasPtrW'(1);
      ras_cnt_d = ras_cnt_q - RasCntW'(1);
    end

    redir_valid_d = accept && pred_taken;
    redir_pc_d    = redir_valid_d ? pred_target : redir_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ras_ptr_q     <= '0;
      ras_cnt_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ras_ptr_q     <= ras_ptr_d;
      ras_cnt_q     <= ras_cnt_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // Storage arrays need no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= new_entry;
    if (!rst && accept && is_call) ras_q[ras_ptr_q] <= pc_plus4;
  end

  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready        = !full;
  assign bus.out_valid       = (count_q != '0);
  assign bus.out_pc          = head.pc;
  assign bus.out_instr       = head.instr;
  assign bus.out_is_jal      = head.is_jal;
  assign bus.out_is_jalr     = head.is_jalr;
  assign bus.out_is_branch   = head.is_branch;
  assign bus.out_is_mv       = head.is_mv;
  assign bus.out_is_sw       = head.is_sw;
  assign bus.out_pred_taken  = head.pred_taken;
  assign bus.out_pred_target = head.pred_target;
  assign bus.redirect_valid  = redir_valid_q;
  assign bus.redirect_pc     = redir_pc_q;

endmodule

// File: tb/tb_predecode_fetch_buffer.sv
module tb_predecode_fetch_buffer;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned XLEN      = 32;

  localparam logic [31:0] ADDI    = 32'h00110113;
  localparam logic [31:0] JAL_X1  = 32'h100000EF;
  localparam logic [31:0] RET     = 32'h00008067;
  localparam logic [31:0] BEQ_BK  = 32'hFE000CE3;
  localparam logic [31:0] BEQ_FWD = 32'h00000463;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  predecode_fetch_buffer_if #(.XLEN(XLEN)) bus ();

  predecode_fetch_buffer #(.DEPTH(DEPTH), .RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic jal, jalr, br, mv, sw, taken;
    logic [31:0] target;
  } ent_t;

  // Reference model: FIFO as a queue, RAS as a queue whose back is the top.
  ent_t        q[$];
  logic [31:0] ras[$];
  bit          exp_rv;
  logic [31:0] exp_rpc;
  bit          rpc_known;
  bit          zero_after_reset;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t predict(input logic [31:0] pc, input logic [31:0] instr);
    ent_t e;
    int   imm;
    logic [6:0] op;
    logic [2:0] f3;
    op = instr[6:0];
    f3 = instr[14:12];
    e.pc     = pc;
    e.instr  = instr;
    e.jal    = (op == 7'h6F);
    e.jalr   = (op == 7'h67);
    e.br     = (op == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
    e.mv     = (op == 7'h13) && (f3 == 3'd0) && (instr[31:20] == 12'd0);
    e.sw     = (op == 7'h23) && (f3 == 3'd2);
    e.taken  = 1'b0;
    e.target = pc + 32'd4;
    if (e.jal) begin
      imm = int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096
            - (instr[31] ? 1048576 : 0);
      e.taken  = 1'b1;
      e.target = pc + 32'(imm);
    end else if (e.br) begin
      imm = int'(instr[11:8]) * 2 + int'(instr[30:25]) * 32 + int'(instr[7]) * 2048
            - (instr[31] ? 4096 : 0);
      if (imm < 0) begin
        e.taken  = 1'b1;
        e.target = pc + 32'(imm);
      end
    end else if (e.jalr && instr[11:7] == 5'd0 && instr[19:15] == 5'd1 && ras.size() > 0) begin
      e.taken  = 1'b1;
      e.target = ras[ras.size()-1] & ~32'd1;
    end
    return e;
  endfunction

  task automatic model_edge();
    ent_t e;
    bit   acc, deq;
    if (rst) begin
      q.delete();
      ras.delete();
      exp_rv           = 1'b0;
      exp_rpc          = '0;
      rpc_known        = 1'b1;
      zero_after_reset = 1'b1;
      return;
    end
    acc = bus.in_valid && (q.size() < DEPTH) && !flush;
    deq = (q.size() > 0) && bus.out_ready;
    e   = predict(bus.in_pc, bus.in_instr);
    if (flush) begin
      q.delete();
      exp_rv    = 1'b0;
      rpc_known = 1'b0;
      return;
    end
    if (deq) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      zero_after_reset = 1'b0;
      if ((e.jal || e.jalr) && e.instr[11:7] == 5'd1) begin
        ras.push_back(e.pc + 32'd4);
        if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
      end else if (e.jalr && e.instr[11:7] == 5'd0 && e.instr[19:15] == 5'd1 && ras.size() > 0) begin
        void'(ras.pop_back());
      end
    end
    exp_rv    = acc && e.taken;
    rpc_known = exp_rv;
    if (exp_rv) exp_rpc = e.target;
  endtask

  task automatic check_all();
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    chk("redirect_valid", bus.redirect_valid, exp_rv);
    if (rpc_known) chk("redirect_pc", bus.redirect_pc, exp_rpc);
    if (q.size() > 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_instr", bus.out_instr, q[0].instr);
      chk("out_flags", {bus.out_is_jal, bus.out_is_jalr, bus.out_is_branch, bus.out_is_mv,
                        bus.out_is_sw, bus.out_pred_taken},
          {q[0].jal, q[0].jalr, q[0].br, q[0].mv, q[0].sw, q[0].taken});
      chk("out_pred_target", bus.out_pred_target, q[0].target);
    end else if (zero_after_reset) begin
      chk("reset out data", {bus.out_pc, bus.out_instr, bus.out_pred_target}, '0);
      chk("reset out flags", {bus.out_is_jal, bus.out_is_jalr, bus.out_is_branch, bus.out_is_mv,
                              bus.out_is_sw, bus.out_pred_taken}, '0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rdv;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: begin
        rdv = ($urandom_range(0, 2) == 0) ? 5'd0 : (($urandom_range(0, 1) == 0) ? 5'd1 : 5'd5);
        return {r[31:12], rdv, 7'h6F};
      end
      1: return {r[31:20], ($urandom_range(0, 1) == 0) ? 5'd1 : 5'd5, 3'b000,
                 ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd1, 7'h67};
      2: return RET;
      3: return {r[31:7], 7'h63};
      4: return ($urandom_range(0, 1) == 0) ? {12'h000, r[19:15], 3'b000, r[11:7], 7'h13}
                                            : {r[31:7], 7'h13};
      5: return ($urandom_range(0, 1) == 0) ? {r[31:15], 3'b010, r[11:7], 7'h23}
                                            : {r[31:7], 7'h23};
      default: return r;
    endcase
  endfunction

  int acc_cnt;

  initial begin
    drive(0, '0, '0, 0, 0);
    rst = 1'b1;
    step();
    step();
    chk("reset out_pc literal", bus.out_pc, 32'h0);
    chk("reset redirect literal", {bus.redirect_valid, bus.redirect_pc}, 33'h0);
    rst = 1'b0;

    // Stream 6 plain instructions into a stalled decode: only DEPTH fit.
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h100 + 32'(4 * k), ADDI, 0, 0);
      if (bus.in_ready) acc_cnt++;
      step();
    end
    chk("stream accepted", 32'(acc_cnt), 32'd4);
    chk("stream head pc", bus.out_pc, 32'h100);
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 5; k++) step();

    // Call then return through the RAS.
    drive(1, 32'h1000, JAL_X1, 1, 0);
    step();
    chk("jal flag", bus.out_is_jal, 1'b1);
    chk("jal target", bus.out_pred_target, 32'h1100);
    chk("jal redirect", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h1100});
    drive(1, 32'h1100, RET, 1, 0);
    step();
    chk("ret taken", bus.out_pred_taken, 1'b1);
    chk("ret target", bus.out_pred_target, 32'h1004);
    drive(1, 32'h1104, RET, 1, 0);
    step();
    chk("ret empty ras", {bus.out_pred_taken, bus.out_pred_target}, {1'b0, 32'h1108});

    // Backward taken / forward not taken branches.
    drive(1, 32'h2008, BEQ_BK, 1, 0);
    step();
    chk("beq back", {bus.out_is_branch, bus.out_pred_taken, bus.out_pred_target},
        {2'b11, 32'h2000});
    chk("beq back redirect", bus.redirect_pc, 32'h2000);
    drive(1, 32'h3000, BEQ_FWD, 1, 0);
    step();
    chk("beq fwd", {bus.out_pred_taken, bus.out_pred_target, bus.redirect_valid},
        {1'b0, 32'h3004, 1'b0});

    // Nine calls overflow the 8-entry RAS; nine returns unwind it.
    for (int k = 0; k < 9; k++) begin
      drive(1, 32'h4000 + 32'(k * 32'h100), JAL_X1, 1, 0);
      step();
    end
    for (int k = 0; k < 9; k++) begin
      drive(1, 32'h5000 + 32'(4 * k), RET, 1, 0);
      step();
      if (k < 8) chk("ras lifo", {bus.out_pred_taken, bus.out_pred_target},
                     {1'b1, 32'h4804 - 32'(k * 32'h100)});
      else chk("ras underflow", {bus.out_pred_taken, bus.out_pred_target},
               {1'b0, 32'h5000 + 32'(4 * k + 4)});
    end

    // Flush against a full FIFO and a concurrent call; the RAS must survive.
    drive(1, 32'h6000, JAL_X1, 1, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h6100 + 32'(4 * k), ADDI, 0, 0);
      step();
    end
    drive(1, 32'h7000, JAL_X1, 0, 1);
    step();
    chk("flush full", {bus.out_valid, bus.redirect_valid, bus.in_ready}, 3'b001);
    drive(1, 32'h7004, ADDI, 0, 0);
    step();
    drive(1, 32'h7100, JAL_X1, 0, 1);
    step();
    chk("flush drop", {bus.out_valid, bus.redirect_valid}, 2'b00);
    drive(1, 32'h7200, RET, 1, 0);
    step();
    chk("ras after flush", {bus.out_pred_taken, bus.out_pred_target}, {1'b1, 32'h6004});

    // Overlapped enqueue/dequeue with two entries in flight.
    drive(0, '0, '0, 1, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h8000 + 32'(4 * k), ADDI, 0, 0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, 32'h8008 + 32'(4 * k), ADDI, 1, 0);
      step();
      chk("overlap head pc", bus.out_pc, 32'h8000 + 32'(4 * (k + 1)));
    end
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++) step();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, rand_instr(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
